// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes and a held carry for ADC/SBC chaining.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for opcode 1011.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             err
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_XOR = 4'b0100, OP_NOT = 4'b0101, OP_SHL = 4'b0110, OP_SHR = 4'b0111,
    OP_ADC = 4'b1000, OP_SBC = 4'b1001, OP_CMP = 4'b1010, OP_MUL = 4'b1011
  } op_e;

  logic           c_flag;
  logic           accept;
  logic [WIDTH:0] alu_res;
  logic           alu_err;
  logic           alu_upd;
  logic           is_mul;
  logic           ld;
  logic [WIDTH:0] ld_res;
  logic           ld_err;
  logic           ld_upd;

  assign accept = in_valid && in_ready;
  assign carry  = result[WIDTH];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_upd = 1'b0;
    is_mul  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin alu_res = {1'b0, a} + {1'b0, b}; alu_upd = 1'b1; end
      OP_SUB: begin alu_res = {1'b0, a} - {1'b0, b}; alu_upd = 1'b1; end
      OP_AND: alu_res = {1'b0, a & b};
      OP_OR:  alu_res = {1'b0, a | b};
      OP_XOR: alu_res = {1'b0, a ^ b};
      OP_NOT: alu_res = {1'b0, ~a};
      OP_SHL: begin alu_res = {a, 1'b0}; alu_upd = 1'b1; end
      OP_SHR: begin alu_res = {a[0], 1'b0, a[WIDTH-1:1]}; alu_upd = 1'b1; end
      OP_ADC: begin alu_res = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c_flag); alu_upd = 1'b1; end
      OP_SBC: begin alu_res = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(c_flag); alu_upd = 1'b1; end
      OP_CMP: alu_res = {1'b0, a} - {1'b0, b};
`ifdef ALU_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic               mul_start;
  logic               mul_last;
  logic [WIDTH:0]     mul_res;

  assign mul_start = accept && is_mul;
  assign mul_last  = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign acc_nx    = mplier[0] ? acc + mcand : acc;
  // The final iteration loads the output directly from the next accumulator value.
  assign mul_res   = {|acc_nx[2*WIDTH-1:WIDTH], acc_nx[WIDTH-1:0]};
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mul_start) state_nx = BUSY;
      BUSY: if (mul_last)  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (state == BUSY) begin
      cnt    <= cnt + CNT_W'(1);
      mcand  <= mcand << 1;
      acc    <= acc_nx;
      mplier <= mplier >> 1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    ld     = accept && !is_mul;
    ld_res = alu_res;
    ld_err = alu_err;
    ld_upd = alu_upd;
`ifdef ALU_MUL_EN
    if (mul_last) begin
      ld     = 1'b1;
      ld_res = mul_res;
      ld_err = 1'b0;
      ld_upd = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      err       <= 1'b0;
      c_flag    <= 1'b0;
    end else begin
      if (ld) begin
        out_valid <= 1'b1;
        result    <= ld_res;
        zero      <= ~|ld_res[WIDTH-1:0];
        negative  <= ld_res[WIDTH-1];
        err       <= ld_err;
        if (ld_upd) c_flag <= ld_res[WIDTH];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random scoreboard bench for alu_pipe at WIDTH=4.
// The multiplier section is compiled only when ALU_MUL_EN is defined.
module tb_alu_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .negative(negative), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic mc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: compare every transferred result against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, ".result"},   32'(result),   32'(e.res));
        check({e.tag, ".carry"},    32'(carry),    32'(e.res[W]));
        check({e.tag, ".zero"},     32'(zero),     32'(e.res[W-1:0] == '0));
        check({e.tag, ".negative"}, 32'(negative), 32'(e.res[W-1]));
        check({e.tag, ".err"},      32'(err),      32'(e.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W:0] er, input logic ee);
    exp_t n;
    n.res = er;
    n.err = ee;
    n.tag = tag;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    sb.push_back(n);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output logic [W:0] r, output logic ee, output logic upd);
    int xi;
    int yi;
    xi  = int'(x);
    yi  = int'(y);
    r   = '0;
    ee  = 1'b0;
    upd = 1'b1;
    case (o)
      4'd0:  r = (W+1)'(xi + yi);
      4'd1:  r = (W+1)'(xi - yi);
      4'd2:  begin r = {1'b0, x & y}; upd = 1'b0; end
      4'd3:  begin r = {1'b0, x | y}; upd = 1'b0; end
      4'd4:  begin r = {1'b0, x ^ y}; upd = 1'b0; end
      4'd5:  begin r = {1'b0, ~x};    upd = 1'b0; end
      4'd6:  r = (W+1)'(xi * 2);
      4'd7:  r = {x[0], W'(xi / 2)};
      4'd8:  r = (W+1)'(xi + yi + int'(c));
      4'd9:  r = (W+1)'(xi - yi - int'(c));
      4'd10: begin r = (W+1)'(xi - yi); upd = 1'b0; end
      default: begin ee = 1'b1; upd = 1'b0; end
    endcase
  endtask

  initial begin
    logic [W:0]   r;
    logic         ee;
    logic         upd;
    logic [3:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result",    32'(result),    32'd0);
    check("reset.flags",     32'({carry, zero, negative, err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue("add_a6",   4'b0000, 4'b1010, 4'b0110, 5'b10000, 1'b0);
    issue("sub_eq",   4'b0001, 4'b1010, 4'b1010, 5'b00000, 1'b0);
    issue("sub_brw",  4'b0001, 4'b0010, 4'b0110, 5'b11100, 1'b0);
    issue("add_wrap", 4'b0000, 4'b1111, 4'b0001, 5'b10000, 1'b0);
    issue("adc_c1",   4'b1000, 4'b0001, 4'b0001, 5'b00011, 1'b0);
    issue("adc_c0",   4'b1000, 4'b0001, 4'b0001, 5'b00010, 1'b0);
    issue("sub_c0",   4'b0001, 4'b0011, 4'b0001, 5'b00010, 1'b0);
    issue("cmp_brw",  4'b1010, 4'b0000, 4'b0001, 5'b11111, 1'b0);
    issue("adc_cmp",  4'b1000, 4'b0000, 4'b0000, 5'b00000, 1'b0);
    issue("and",      4'b0010, 4'b1100, 4'b1010, 5'b01000, 1'b0);
    issue("or",       4'b0011, 4'b1100, 4'b1010, 5'b01110, 1'b0);
    issue("xor",      4'b0100, 4'b1100, 4'b1010, 5'b00110, 1'b0);
    issue("not",      4'b0101, 4'b1100, 4'b0000, 5'b00011, 1'b0);
    issue("shl",      4'b0110, 4'b1001, 4'b0000, 5'b10010, 1'b0);
    issue("shr",      4'b0111, 4'b1001, 4'b0000, 5'b10100, 1'b0);
    issue("sub_set",  4'b0001, 4'b0000, 4'b0001, 5'b11111, 1'b0);
    issue("sbc_c1",   4'b1001, 4'b0101, 4'b0010, 5'b00010, 1'b0);
    issue("sbc_c0",   4'b1001, 4'b0000, 4'b0000, 5'b00000, 1'b0);
    issue("add_set",  4'b0000, 4'b1111, 4'b0001, 5'b10000, 1'b0);
    issue("ill_1100", 4'b1100, 4'b0111, 4'b0001, 5'b00000, 1'b1);
    issue("adc_ill",  4'b1000, 4'b0000, 4'b0000, 5'b00001, 1'b0);
`ifndef ALU_MUL_EN
    issue("mul_ill",  4'b1011, 4'b0011, 4'b0101, 5'b00000, 1'b1);
`endif
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: the result must hold while out_ready is low.
    out_ready = 1'b0;
    issue("bp_and", 4'b0010, 4'b1010, 4'b0110, 5'b00010, 1'b0);
    in_valid = 1'b0;
    a = 4'b1111;
    b = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.result",    32'(result),    32'b00010);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.in_ready_rel", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp.drained", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

`ifdef ALU_MUL_EN
    issue("mul_3x5", 4'b1011, 4'b0011, 4'b0101, 5'b01111, 1'b0);
    in_valid = 1'b0;
    a = 4'b1111;
    b = 4'b1111;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin
      check("mul.in_ready_busy", 32'(in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    check("mul.latency", 32'(n), 32'(W));
    @(posedge clk);
    #1;
    issue("mul_ax6", 4'b1011, 4'b1010, 4'b0110, 5'b11100, 1'b0);
    in_valid = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    issue("adc_mul", 4'b1000, 4'b0000, 4'b0000, 5'b00001, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset two cycles into a multiply: no output may appear.
    issue("mul_abort", 4'b1011, 4'b0111, 4'b0111, 5'b00000, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check("abort.out_valid_rst", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("abort.out_valid", 32'(out_valid), 32'd0);
      check("abort.in_ready",  32'(in_ready),  32'd1);
    end
    @(posedge clk);
    #1;
`else
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
`endif
    issue("ill_1101", 4'b1101, 4'b1010, 4'b0101, 5'b00000, 1'b1);
    issue("adc_rst",  4'b1000, 4'b0001, 4'b0001, 5'b00010, 1'b0);

    // Random legal/illegal single-cycle ops against the arithmetic model.
    issue("clr_c", 4'b0000, 4'b0000, 4'b0000, 5'b00000, 1'b0);
    mc = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
      if (ro == 4'b1011) ro = 4'b1000;
`endif
      ra = W'($urandom);
      rb = W'($urandom);
      model(ro, ra, rb, mc, r, ee, upd);
      if (upd) mc = r[W];
      issue($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, r, ee);
    end
    in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain.queue_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
